// File: rtl/mole_round_if.sv
// Game-side bundle of the whack-a-mole sequencer: start/button inputs
// and the mole, score and status outputs seen by the LED/score logic.
interface mole_round_if;
    logic       start;
    logic [7:0] btn;
    logic [7:0] mole;
    logic [7:0] score;
    logic [4:0] round_num;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       busy;
    logic       done;

    modport master (
        output start, btn,
        input  mole, score, round_num, hit_pulse, miss_pulse, busy, done
    );

    modport slave (
        input  start, btn,
        output mole, score, round_num, hit_pulse, miss_pulse, busy, done
    );
endinterface

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: dark gap, pseudo-random lit mole with a
// shrinking window, hit/miss judgement, score and round bookkeeping.
module mole_round_scheduler #(
    parameter int unsigned N_ROUNDS  = 16,
    parameter int unsigned WIN_INIT  = 50000,
    parameter int unsigned WIN_STEP  = 2000,
    parameter int unsigned WIN_MIN   = 10000,
    parameter int unsigned GAP_CYC   = 20000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    mole_round_if.slave    bus
);
    localparam logic [15:0] WIN_INIT_C = 16'(WIN_INIT);
    localparam logic [15:0] WIN_STEP_C = 16'(WIN_STEP);
    localparam logic [15:0] WIN_MIN_C  = 16'(WIN_MIN);
    localparam logic [15:0] GAP_LOAD_C = 16'(GAP_CYC - 1);
    localparam logic [4:0]  ROUNDS_C   = 5'(N_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_SHOW  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1 (feedback from bits 7,5,4,3).
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    state_t      state_r;
    logic [7:0]  lfsr_r;
    logic [7:0]  btn_q_r;
    logic [15:0] cnt_r;
    logic [15:0] window_r;
    logic [2:0]  prev_idx_r;
    logic        prev_valid_r;
    logic [7:0]  mole_r;
    logic [7:0]  score_r;
    logic [4:0]  round_r;
    logic        hit_r;
    logic        miss_r;
    logic        busy_r;
    logic        done_r;

    logic [7:0]  press_s;
    logic        wrong_s;
    logic        right_s;
    logic [2:0]  idx_s;
    logic [15:0] win_next_s;
    logic [7:0]  score_next_s;

    // Rising-edge press detection and classification against the lit mole.
    always_comb begin
        press_s = bus.btn & ~btn_q_r;
        wrong_s = |(press_s & ~mole_r);
        right_s = |(press_s & mole_r);
    end

    // Mole choice: never light the same hole twice in a row within a game.
    always_comb begin
        idx_s = lfsr_r[2:0];
        if (prev_valid_r && (lfsr_r[2:0] == prev_idx_r)) begin
            idx_s = lfsr_r[2:0] + 3'd1;
        end else begin
            idx_s = lfsr_r[2:0];
        end
    end

    // Post-hit window shrink with floor (compare first so it cannot wrap) and saturating score.
    always_comb begin
        win_next_s   = WIN_MIN_C;
        score_next_s = score_r;
        if ({1'b0, window_r} >= ({1'b0, WIN_MIN_C} + {1'b0, WIN_STEP_C})) begin
            win_next_s = window_r - WIN_STEP_C;
        end else begin
            win_next_s = WIN_MIN_C;
        end
        if (score_r == 8'hFF) begin
            score_next_s = score_r;
        end else begin
            score_next_s = score_r + 8'd1;
        end
    end

    // Game FSM with all outputs registered; LFSR and button history run every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= LFSR_SEED;
            btn_q_r      <= 8'hFF;
            cnt_r        <= 16'd0;
            window_r     <= WIN_INIT_C;
            prev_idx_r   <= 3'd0;
            prev_valid_r <= 1'b0;
            mole_r       <= 8'd0;
            score_r      <= 8'd0;
            round_r      <= 5'd0;
            hit_r        <= 1'b0;
            miss_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            lfsr_r  <= lfsr_step(lfsr_r);
            btn_q_r <= bus.btn;
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_r      <= ST_GAP;
                        cnt_r        <= GAP_LOAD_C;
                        score_r      <= 8'd0;
                        round_r      <= 5'd0;
                        window_r     <= WIN_INIT_C;
                        prev_valid_r <= 1'b0;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == 16'd0) begin
                        state_r      <= ST_SHOW;
                        mole_r       <= 8'd1 << idx_s;
                        prev_idx_r   <= idx_s;
                        prev_valid_r <= 1'b1;
                        cnt_r        <= window_r - 16'd1;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (wrong_s || right_s || (cnt_r == 16'd0)) begin
                        state_r <= ST_JUDGE;
                        mole_r  <= 8'd0;
                        round_r <= round_r + 5'd1;
                        if (right_s && !wrong_s) begin
                            hit_r    <= 1'b1;
                            score_r  <= score_next_s;
                            window_r <= win_next_s;
                        end else begin
                            miss_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_JUDGE: begin
                    if (round_r == ROUNDS_C) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_GAP;
                        cnt_r   <= GAP_LOAD_C;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mole_r  <= 8'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mole       = mole_r;
    assign bus.score      = score_r;
    assign bus.round_num  = round_r;
    assign bus.hit_pulse  = hit_r;
    assign bus.miss_pulse = miss_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule
